// File: rtl/cone_eval_scheduler.sv
// Round-robin arbiter sharing one combinational cone among NUM_REQ requesters; grant -> rsp_valid after EVAL_CYCLES+1 cycles.
// Backpressure: the response is held stable until rsp_ready, and no new grant is issued until it has been accepted.
module cone_eval_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int IN_W        = 7,
  parameter int OUT_W       = 1,
  parameter int ID_W        = 2,
  parameter int EVAL_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IN_W-1:0]   req_vec,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [IN_W-1:0]           cone_in,
  input  logic [OUT_W-1:0]          cone_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [OUT_W-1:0]          rsp_data,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_cnt
);

  localparam int EC_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [EC_W-1:0]    r_eval_cnt;
  logic [IN_W-1:0]    r_cone_in;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [OUT_W-1:0]   r_rsp_data;
  logic [CNT_W-1:0]   r_done_cnt;

  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [IN_W-1:0]    w_gnt_vec;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]    w_nxt_ptr;
  int                 w_dist;
  int                 w_best;

  // Winner is the valid requester with the smallest circular distance from r_rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_gnt_vec = '0;
    w_gnt_oh  = '0;
    w_nxt_ptr = '0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_vld = 1'b1;
        w_gnt_id  = ID_W'(i);
        w_gnt_vec = req_vec[i*IN_W +: IN_W];
        w_gnt_oh  = '0;
        w_gnt_oh[i] = 1'b1;
        w_nxt_ptr = (i == NUM_REQ-1) ? '0 : ID_W'(i+1);
      end
    end
  end

  // rst_n gating keeps req_ready low for the whole reset window, not just after the first edge.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt_oh : '0;
  assign busy      = (r_state != IDLE);
  assign cone_in   = r_cone_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign done_cnt  = r_done_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_eval_cnt  <= '0;
      r_cone_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_cone_in  <= w_gnt_vec;
            r_rsp_id   <= w_gnt_id;
            r_rr_ptr   <= w_nxt_ptr;
            r_eval_cnt <= EC_W'(EVAL_CYCLES-1);
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          if (r_eval_cnt != '0) begin
            r_eval_cnt <= r_eval_cnt - EC_W'(1);
          end else begin
            r_rsp_data  <= cone_out;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (~&r_done_cnt) r_done_cnt <= r_done_cnt + CNT_W'(1);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cone_eval_scheduler.md
Name: cone_eval_scheduler

Overview:
- Round-robin scheduler that shares one combinational timing cone (7 inputs, 1 output) among NUM_REQ requesters.
- Grants one request at a time, drives the grant's vector onto the cone inputs and holds it for EVAL_CYCLES cycles (multicycle settle budget).
- Then captures the cone output and returns it with the requester ID over a valid/ready response channel.
- Sits between the stimulus/test-harness masters and the cone instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IN_W, 7, cone input width
- OUT_W, 1, cone output width
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ
- EVAL_CYCLES, 2, cycles cone_in is held stable before capture (>=1)
- CNT_W, 16, completed-evaluation counter width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_vec  input  NUM_REQ*IN_W  per-requester input vector; requester i occupies bits [i*IN_W +: IN_W]
- req_ready  output  NUM_REQ  one-hot grant/accept
- cone_in  output  IN_W  registered drive to shared cone inputs
- cone_out  input  OUT_W  cone result
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  ID_W  index of served requester
- rsp_data  output  OUT_W  captured cone_out
- busy  output  1  high whenever state != IDLE
- done_cnt  output  CNT_W  completed responses, saturating

Behaviour:
- Reset: asynchronous, active-low. Values while rst_n is low:
  - state=IDLE, rr_ptr=0
  - cone_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, done_cnt=0
  - req_ready=0, busy=0
- Reset mid-operation: an in-flight request is dropped and no response is issued. Requesters re-present after reset.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot(grant) combinationally, only in IDLE; zero in all other states.
  - If any req_valid is high, the handshake completes this cycle. At the edge:
    - cone_in <= req_vec[grant]
    - rsp_id <= grant
    - rr_ptr <= (grant+1) mod NUM_REQ
    - eval_cnt <= EVAL_CYCLES-1
    - state <= EVAL
  - If no req_valid is high: stay in IDLE; rr_ptr is unchanged.
- EVAL:
  - cone_in is held constant.
  - If eval_cnt != 0: decrement eval_cnt.
  - If eval_cnt == 0: rsp_data <= cone_out, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid <= 0, done_cnt increments (saturates at all-ones), state <= IDLE.
  - No new grant is issued in the handshake cycle.
- Latency: handshake in cycle t -> cone_in valid in cycle t+1 -> rsp_valid first high in cycle t+1+EVAL_CYCLES, given no backpressure.
- Throughput: one evaluation per EVAL_CYCLES+2 cycles at most.
- cone_in retains its last vector after completion; it is not cleared.
- Requesters must hold req_valid and req_vec until they see req_ready. Deasserting earlier withdraws the request with no side effects.
- Simultaneous requests are resolved purely by rr_ptr. A requester that is continuously valid is served within NUM_REQ grants (no starvation).
- A cone_out change during RESP does not alter rsp_data.

Test Plan:
- Single request, EVAL_CYCLES=2: req_valid=4'b0001, req_vec[0]=7'h55 at cycle 0. Expect req_ready=4'b0001 in cycle 0, cone_in=7'h55 from cycle 1, rsp_valid high in cycle 3 with rsp_id=0 and rsp_data equal to cone_out sampled at the end of cycle 2, done_cnt=1 after the response handshake.
- All four requesters held valid with rsp_ready=1: grant order 0,1,2,3,0; each rsp_id matches; consecutive req_ready pulses are 4 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles while in RESP, with cone_out toggling. rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0; one response is delivered once rsp_ready=1.
- Fairness: req_valid=4'b1001 after serving requester 0 (rr_ptr=1): requester 3 is granted before requester 0.
- Reset mid-EVAL: assert rst_n=0 in cycle t+1. Outputs go to reset values immediately, without waiting for a clock edge; no response is issued; the next request after release is granted with rr_ptr=0 priority.
- EVAL_CYCLES=1 and CNT_W=2: rsp_valid appears in cycle t+2; after 5 completed transactions done_cnt holds at 3.
